// File: rtl/led_scan_if.sv
// Control/status bundle between the scan sequencer and whoever drives it
// (push-button synchronisers or a CPU strobe register).
interface led_scan_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] pattern;
  logic             busy;
  logic             sweep_done;

  modport master (output start, stop, mode, div, input pattern, busy, sweep_done);
  modport slave  (input start, stop, mode, div, output pattern, busy, sweep_done);
endinterface

// File: rtl/led_scan_ctrl.sv
// One-hot LED scanner sequencer: end hold, bounce/wrap sweeps, graceful stop.
// Optional freeze input enabled by defining LED_SCAN_PAUSE_EN.
module led_scan_ctrl #(
  parameter int WIDTH    = 8,
  parameter int END_HOLD = 3,
  parameter int DIV_W    = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef LED_SCAN_PAUSE_EN
  input  logic pause,
`endif
  led_scan_if.slave bus
);
  localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] POS_LAST  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_TURN  = PW'(WIDTH - 2);
  localparam logic [3:0]    HOLD_LAST = 4'(END_HOLD);

  typedef enum logic [1:0] {IDLE, HOLD, UP, DOWN} state_t;

  state_t           state;
  logic [PW-1:0]    pos, pos_nxt;
  logic [3:0]       hold_cnt;
  logic [DIV_W-1:0] presc, div_q;
  logic             mode_q, stop_pending;
  logic [WIDTH-1:0] pattern_q;
  logic             busy_q, sweep_done_q;
  logic             frozen, tick, sweep_end;

`ifdef LED_SCAN_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  assign tick = (state != IDLE) && !frozen && (presc == div_q);

  // Next position and end-of-sweep detection, both only on ticks
  always_comb begin
    pos_nxt   = pos;
    sweep_end = 1'b0;
    if (tick) begin
      case (state)
        HOLD: if (hold_cnt == HOLD_LAST) pos_nxt = PW'(1);
        UP: begin
          if (pos == POS_LAST) begin
            pos_nxt   = mode_q ? '0 : POS_TURN;
            sweep_end = mode_q;
          end else begin
            pos_nxt = pos + PW'(1);
          end
        end
        DOWN: begin
          pos_nxt   = pos - PW'(1);
          sweep_end = (pos == PW'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pos          <= '0;
      hold_cnt     <= '0;
      presc        <= '0;
      div_q        <= '0;
      mode_q       <= 1'b0;
      stop_pending <= 1'b0;
      pattern_q    <= WIDTH'(1);
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      pos          <= pos_nxt;
      pattern_q    <= WIDTH'(1) << pos_nxt;
      if (state != IDLE && !frozen)
        presc <= (presc == div_q) ? '0 : presc + DIV_W'(1);
      if (state != IDLE && bus.stop)
        stop_pending <= 1'b1;

      case (state)
        IDLE: if (bus.start) begin
          mode_q       <= bus.mode;
          div_q        <= bus.div;
          hold_cnt     <= '0;
          presc        <= '0;
          stop_pending <= bus.stop;
          busy_q       <= 1'b1;
          state        <= HOLD;
        end
        HOLD: if (tick) begin
          if (hold_cnt == HOLD_LAST) state <= UP;
          else                       hold_cnt <= hold_cnt + 4'd1;
        end
        UP:      if (tick && pos == POS_LAST && !mode_q) state <= DOWN;
        default: ;
      endcase

      // A pending stop seen at the sweep end wins over a stop arriving this cycle
      if (sweep_end) begin
        sweep_done_q <= 1'b1;
        hold_cnt     <= '0;
        if (stop_pending) begin
          state        <= IDLE;
          busy_q       <= 1'b0;
          stop_pending <= 1'b0;
        end else begin
          state <= HOLD;
        end
      end
    end
  end

  assign bus.pattern    = pattern_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: directed test-plan steps plus randomized runs,
// checked each cycle against a tick-count model of the sweep.
module tb_led_scan_ctrl;
  localparam int WIDTH = 8, END_HOLD = 3, DIV_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pause = 1'b0;
  int   errors = 0, checks = 0;

  // model state: active flag, unpaused edges since start, latched config
  bit   m_act, m_stop, m_done, m_md;
  int   m_n, m_dv;

  led_scan_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

  led_scan_ctrl #(.WIDTH(WIDTH), .END_HOLD(END_HOLD), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef LED_SCAN_PAUSE_EN
    .pause (pause),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int sweep_len(bit md);
    return md ? END_HOLD + WIDTH : END_HOLD + 2 * (WIDTH - 1);
  endfunction

  // position after k ticks into a sweep
  function automatic int pos_of(int k, bit md);
    int j = k - END_HOLD;
    if (j <= 0) return 0;
    if (j <= WIDTH - 1) return j;
    return md ? 0 : 2 * (WIDTH - 1) - j;
  endfunction

  task automatic step();
    int t, tp;
    logic [31:0] ep;
    @(posedge clk);
    m_done = 0;
    if (!m_act) begin
      if (bus.start) begin
        m_act = 1; m_n = 0; m_md = bus.mode; m_dv = int'(bus.div); m_stop = bus.stop;
      end
    end else begin
      if (!pause) begin
        m_n++;
        t  = m_n / (m_dv + 1);
        tp = (m_n - 1) / (m_dv + 1);
        m_done = (t != tp) && (t % sweep_len(m_md) == 0);
      end
      if (m_done && m_stop) begin
        m_act = 0; m_stop = 0;
      end else if (bus.stop) begin
        m_stop = 1;
      end
    end
    #1;
    ep = m_act ? (32'd1 << pos_of((m_n / (m_dv + 1)) % sweep_len(m_md), m_md)) : 32'd1;
    check("pattern", 32'(bus.pattern), ep);
    check("busy", 32'(bus.busy), 32'(m_act));
    check("sweep_done", 32'(bus.sweep_done), 32'(m_done));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_act = 0; m_stop = 0; m_done = 0; m_n = 0;
    #1;
    check("rst_pattern", 32'(bus.pattern), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.sweep_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    bus.start = 1'b0; bus.stop = 1'b1; pause = 1'b0;
    for (int i = 0; i < 400 && bus.busy; i++) step();
    check("drain_idle", 32'(bus.busy), 32'd0);
    bus.stop = 1'b0;
  endtask

  initial begin
    int nd, last, done_at;
    bit found;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.div = '0;
    #2;
    do_reset();
    for (int c = 0; c < 10; c++) step();

    // bounce, div 0, stop requested mid-sweep
    bus.mode = 1'b0; bus.div = '0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      bus.stop = (c == 5);
      step();
      if (c == 3)  check("t2_hold", 32'(bus.pattern), 32'h01);
      if (c == 4)  check("t2_pos1", 32'(bus.pattern), 32'h02);
      if (c == 10) check("t2_pos7", 32'(bus.pattern), 32'h80);
      if (c == 11) check("t2_pos6", 32'(bus.pattern), 32'h40);
      if (c == 17) begin
        check("t2_done", 32'(bus.sweep_done), 32'd1);
        check("t2_idle", 32'(bus.busy), 32'd0);
      end
    end

    // one-shot wrap sweep, div 2
    bus.mode = 1'b1; bus.div = DIV_W'(2); bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    nd = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.sweep_done) begin nd++; done_at = c; end
    end
    check("t3_count", 32'(nd), 32'd1);
    check("t3_at", 32'(done_at), 32'd33);

    // continuous bounce, div 1, config noise while busy
    bus.mode = 1'b0; bus.div = DIV_W'(1); bus.start = 1'b1;
    step();
    nd = 0; last = 0;
    for (int c = 1; c <= 110; c++) begin
      bus.mode  = 1'($urandom_range(0, 1));
      bus.div   = DIV_W'($urandom_range(0, 15));
      bus.start = 1'($urandom_range(0, 1));
      step();
      if (bus.sweep_done) begin
        if (nd > 0) check("t4_gap", 32'(c - last), 32'd34);
        else        check("t4_first", 32'(c), 32'd34);
        last = c; nd++;
      end
    end
    check("t4_count", 32'(nd), 32'd3);
    drain();

    // async reset mid-sweep at pattern 0x20, then clean restart
    bus.mode = 1'b0; bus.div = '0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      step();
      found = (bus.pattern == 8'h20);
    end
    check("t5_found", 32'(found), 32'd1);
    #1;
    do_reset();
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int c = 0; c < 20; c++) step();
    check("t5_restart_idle", 32'(bus.busy), 32'd0);

`ifdef LED_SCAN_PAUSE_EN
    // pause 7 cycles at pattern 0x08 delays the sweep end by 7
    bus.mode = 1'b0; bus.div = '0; bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    found = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (!found && bus.pattern == 8'h08) begin
        pause = 1'b1;
        for (int p = 0; p < 7; p++) begin
          step(); c++;
          check("pause_hold", 32'(bus.pattern), 32'h08);
        end
        pause = 1'b0; found = 1;
      end
      step();
      if (bus.sweep_done) done_at = c;
    end
    check("pause_delay", 32'(done_at), 32'd24);
`endif

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      bus.mode  = 1'($urandom_range(0, 1));
      bus.div   = DIV_W'($urandom_range(0, 3));
      bus.start = 1'b1;
      bus.stop  = ($urandom_range(0, 3) == 0);
      step();
      for (int c = 0; c < 150; c++) begin
        bus.start = ($urandom_range(0, 7) == 0);
        bus.stop  = ($urandom_range(0, 60) == 0);
        bus.mode  = 1'($urandom_range(0, 1));
        bus.div   = DIV_W'($urandom_range(0, 15));
`ifdef LED_SCAN_PAUSE_EN
        pause = ($urandom_range(0, 5) == 0);
`endif
        step();
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
